// File: rtl/axbs_lanes_acc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | axbs_lanes_acc                                                     |
// | LANES signed multipliers, MULT_STAGES-deep pipe, per-lane acc.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module axbs_lanes_acc #(
  parameter int LANES       = 4,
  parameter int SIZE_A      = 27,
  parameter int SIZE_B      = 27,
  parameter int MULT_STAGES = 4,
  parameter int ACC_W       = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [LANES*SIZE_A-1:0]  in_a,
  input  logic [LANES*SIZE_B-1:0]  in_b,
  input  logic                     in_acc_en,
  input  logic                     in_acc_clr,
  output logic                     out_valid,
  output logic [LANES*ACC_W-1:0]   out_data
);

  localparam int c_PROD_W = SIZE_A + SIZE_B;

  generate
    if (ACC_W < c_PROD_W) begin : g_acc_w_check
      $error("axbs_lanes_acc: ACC_W must be >= SIZE_A+SIZE_B");
    end
  endgenerate

  logic [MULT_STAGES-1:0] r_vld;
  logic [MULT_STAGES-1:0] r_en;
  logic [MULT_STAGES-1:0] r_clr;
  logic                   r_out_vld;

  // Sideband rides alongside the product so each beat keeps its own mode bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld     <= '0;
      r_en      <= '0;
      r_clr     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_vld[0] <= in_valid;
      r_en[0]  <= in_acc_en;
      r_clr[0] <= in_acc_clr;
      for (int s = 1; s < MULT_STAGES; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_en[s]  <= r_en[s-1];
        r_clr[s] <= r_clr[s-1];
      end
      r_out_vld <= r_vld[MULT_STAGES-1];
    end
  end

  assign out_valid = r_out_vld;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [c_PROD_W-1:0] w_a;
    logic signed [c_PROD_W-1:0] w_b;
    logic signed [c_PROD_W-1:0] r_prod [MULT_STAGES];
    logic signed [ACC_W-1:0]    w_p;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [ACC_W-1:0]    r_out;

    assign w_a   = c_PROD_W'($signed(in_a[i*SIZE_A +: SIZE_A]));
    assign w_b   = c_PROD_W'($signed(in_b[i*SIZE_B +: SIZE_B]));
    assign w_p   = ACC_W'(r_prod[MULT_STAGES-1]);
    assign w_sum = r_acc + w_p;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s < MULT_STAGES; s++) begin
          r_prod[s] <= '0;
        end
      end else begin
        r_prod[0] <= w_a * w_b;
        for (int s = 1; s < MULT_STAGES; s++) begin
          r_prod[s] <= r_prod[s-1];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_acc <= '0;
        r_out <= '0;
      end else if (r_vld[MULT_STAGES-1]) begin
        if (!r_en[MULT_STAGES-1]) begin
          r_out <= w_p;
        end else if (r_clr[MULT_STAGES-1]) begin
          r_acc <= w_p;
          r_out <= w_p;
        end else begin
          r_acc <= w_sum;
          r_out <= w_sum;
        end
      end
    end

    assign out_data[i*ACC_W +: ACC_W] = r_out;
  end

endmodule
`default_nettype wire
